// File: rtl/ins_mem_refill_responder.sv
// ins_mem_refill_responder
//   Memory-side responder for instruction-cache line refills. Takes one line
//   request, reads LINE_WORDS consecutive words from a synchronous instruction
//   memory (one-cycle read latency) and returns them in ascending order as a
//   valid/ready word burst. Each word costs three cycles: READ, WAIT, SEND.
//
// Ports
//   ins_mem_responder_clock_in       rising-edge clock
//   ins_mem_responder_reset_in       synchronous active-low reset
//   ins_mem_responder_req_valid_in   refill request valid
//   ins_mem_responder_req_ready_out  high in IDLE only
//   ins_mem_responder_req_addr_in    byte address anywhere inside the missed line
//   ins_mem_responder_mem_rd_en_out  memory read strobe (READ state)
//   ins_mem_responder_mem_addr_out   memory word address = line base | word counter
//   ins_mem_responder_mem_data_in    read data, valid the cycle after rd_en
//   ins_mem_responder_resp_valid_out response word valid (SEND state)
//   ins_mem_responder_resp_ready_in  cache accepts response word
//   ins_mem_responder_resp_data_out  response word
//   ins_mem_responder_resp_idx_out   word index within the line
//   ins_mem_responder_resp_last_out  final word of the burst
//   ins_mem_responder_busy_out       burst in progress
module ins_mem_refill_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LINE_WORDS     = 4,
  parameter int MEM_ADDR_WIDTH = 10,
  localparam int IDX_W         = $clog2(LINE_WORDS)
) (
  input  logic                      ins_mem_responder_clock_in,
  input  logic                      ins_mem_responder_reset_in,
  input  logic                      ins_mem_responder_req_valid_in,
  output logic                      ins_mem_responder_req_ready_out,
  input  logic [ADDR_WIDTH-1:0]     ins_mem_responder_req_addr_in,
  output logic                      ins_mem_responder_mem_rd_en_out,
  output logic [MEM_ADDR_WIDTH-1:0] ins_mem_responder_mem_addr_out,
  input  logic [DATA_WIDTH-1:0]     ins_mem_responder_mem_data_in,
  output logic                      ins_mem_responder_resp_valid_out,
  input  logic                      ins_mem_responder_resp_ready_in,
  output logic [DATA_WIDTH-1:0]     ins_mem_responder_resp_data_out,
  output logic [IDX_W-1:0]          ins_mem_responder_resp_idx_out,
  output logic                      ins_mem_responder_resp_last_out,
  output logic                      ins_mem_responder_busy_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WAIT = 2'd2,
    ST_SEND = 2'd3
  } state_e;

  // Clears the word-within-line bits so the burst always starts at word 0.
  localparam logic [MEM_ADDR_WIDTH-1:0] LINE_MASK =
    {{(MEM_ADDR_WIDTH-IDX_W){1'b1}}, {IDX_W{1'b0}}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  state_e                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] base_q,  base_d;
  logic [IDX_W-1:0]          cnt_q,   cnt_d;
  logic [DATA_WIDTH-1:0]     data_q,  data_d;

  logic                      last_word;

  // Byte offset and bits above the memory range carry no information here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ins_mem_responder_req_addr_in[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2],
                              ins_mem_responder_req_addr_in[1:0]};

  assign last_word = (cnt_q == LAST_IDX);

  always_ff @(posedge ins_mem_responder_clock_in) begin
    if (!ins_mem_responder_reset_in) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ins_mem_responder_req_valid_in) begin
          base_d  = ins_mem_responder_req_addr_in[MEM_ADDR_WIDTH+1:2] & LINE_MASK;
          cnt_d   = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: state_d = ST_WAIT;
      ST_WAIT: begin
        // Memory drives the word addressed in READ during this cycle.
        data_d  = ins_mem_responder_mem_data_in;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (ins_mem_responder_resp_ready_in) begin
          if (last_word) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + IDX_W'(1);
            state_d = ST_READ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All outputs decode registered state only; resp_ready never reaches them.
  assign ins_mem_responder_req_ready_out  = (state_q == ST_IDLE);
  assign ins_mem_responder_mem_rd_en_out  = (state_q == ST_READ);
  assign ins_mem_responder_mem_addr_out   = base_q | {{(MEM_ADDR_WIDTH-IDX_W){1'b0}}, cnt_q};
  assign ins_mem_responder_resp_valid_out = (state_q == ST_SEND);
  assign ins_mem_responder_resp_data_out  = data_q;
  assign ins_mem_responder_resp_idx_out   = cnt_q;
  assign ins_mem_responder_resp_last_out  = (state_q == ST_SEND) && last_word;
  assign ins_mem_responder_busy_out       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ins_mem_refill_responder.sv
// Testbench for ins_mem_refill_responder: a cycle table for two plain bursts
// followed by hand-written stall, held-request and mid-burst reset sequences.
module tb_ins_mem_refill_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        mem_rd_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_idx;
  logic        resp_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ins_mem_refill_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(4), .MEM_ADDR_WIDTH(10)
  ) dut (
    .ins_mem_responder_clock_in      (clk),
    .ins_mem_responder_reset_in      (rst_n),
    .ins_mem_responder_req_valid_in  (req_valid),
    .ins_mem_responder_req_ready_out (req_ready),
    .ins_mem_responder_req_addr_in   (req_addr),
    .ins_mem_responder_mem_rd_en_out (mem_rd_en),
    .ins_mem_responder_mem_addr_out  (mem_addr),
    .ins_mem_responder_mem_data_in   (mem_data),
    .ins_mem_responder_resp_valid_out(resp_valid),
    .ins_mem_responder_resp_ready_in (resp_ready),
    .ins_mem_responder_resp_data_out (resp_data),
    .ins_mem_responder_resp_idx_out  (resp_idx),
    .ins_mem_responder_resp_last_out (resp_last),
    .ins_mem_responder_busy_out      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous memory with mem[w] = w*0x11.
  always @(posedge clk) begin
    if (mem_rd_en) mem_data <= 32'(mem_addr) * 32'h11;
  end

  // Event monitor sampling 1 ns before each rising edge.
  logic [31:0] hs_data[$];
  logic [1:0]  hs_idx[$];
  int last_cnt = 0;
  int rd_cnt   = 0;
  int acc_cnt  = 0;

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
        if (resp_valid && resp_ready) begin
          hs_data.push_back(resp_data);
          hs_idx.push_back(resp_idx);
          if (resp_last) last_cnt++;
        end
        if (mem_rd_en) rd_cnt++;
        if (req_valid && req_ready) acc_cnt++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        req_valid;
    logic [31:0] addr;
    logic        rr;
    logic        e_ready;
    logic        e_rd;
    logic [9:0]  e_maddr;
    logic        e_valid;
    logic [31:0] e_data;
    logic [1:0]  e_idx;
    logic        e_last;
    logic        e_busy;
  } vec_t;

  typedef logic [31:0] word4_t [4];

  vec_t vecs[$];

  task automatic add_row(input logic rv, input logic [31:0] a, input logic rr,
                         input logic ery, input logic erd, input logic [9:0] ema,
                         input logic ev, input logic [31:0] ed, input logic [1:0] ei,
                         input logic el, input logic eb);
    vec_t v;
    v.req_valid = rv; v.addr = a; v.rr = rr;
    v.e_ready = ery; v.e_rd = erd; v.e_maddr = ema; v.e_valid = ev;
    v.e_data = ed; v.e_idx = ei; v.e_last = el; v.e_busy = eb;
    vecs.push_back(v);
  endtask

  // One full burst with resp_ready held high: accept, then READ/WAIT/SEND per word.
  task automatic add_burst(input logic [31:0] a, input logic [9:0] base, input word4_t d);
    add_row(1, a, 1, 1, 0, 10'h0, 0, 32'h0, 2'd0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      add_row(0, 32'h0, 1, 0, 1, base + 10'(k), 0, 32'h0, 2'(k), 0, 1);
      add_row(0, 32'h0, 1, 0, 0, 10'h0,         0, 32'h0, 2'(k), 0, 1);
      add_row(0, 32'h0, 1, 0, 0, 10'h0,         1, d[k],  2'(k), (k == 3), 1);
    end
  endtask

  task automatic wait_send(input logic [1:0] idx, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (resp_valid && resp_idx == idx) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk); #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic ok;
    int   base_hs;
    int   base_last;
    int   seen_valid;

    rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; resp_ready = 1'b0;

    // Reset for two cycles.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready",  32'(req_ready),  32'd1);
    chk("rst_rd_en",      32'(mem_rd_en),  32'd0);
    chk("rst_mem_addr",   32'(mem_addr),   32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_last",  32'(resp_last),  32'd0);
    chk("rst_resp_idx",   32'(resp_idx),   32'd0);
    chk("rst_resp_data",  resp_data,       32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    rst_n = 1'b1;

    // Table: burst at 0x48 (words 0x10..0x13), then 0xFFFF_FFFC (0x3FC..0x3FF).
    add_burst(32'h0000_0048, 10'h010, '{32'h110, 32'h121, 32'h132, 32'h143});
    add_burst(32'hFFFF_FFFC, 10'h3FC, '{32'h43BC, 32'h43CD, 32'h43DE, 32'h43EF});
    add_row(0, 32'h0, 1, 1, 0, 10'h0, 0, 32'h0, 2'd0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      req_valid  = vecs[i].req_valid;
      req_addr   = vecs[i].addr;
      resp_ready = vecs[i].rr;
      #1;
      chk($sformatf("v%0d_req_ready", i),  32'(req_ready),  32'(vecs[i].e_ready));
      chk($sformatf("v%0d_rd_en", i),      32'(mem_rd_en),  32'(vecs[i].e_rd));
      chk($sformatf("v%0d_resp_valid", i), 32'(resp_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_resp_last", i),  32'(resp_last),  32'(vecs[i].e_last));
      chk($sformatf("v%0d_busy", i),       32'(busy),       32'(vecs[i].e_busy));
      if (vecs[i].e_rd)
        chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_maddr));
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_resp_data", i), resp_data,      vecs[i].e_data);
        chk($sformatf("v%0d_resp_idx", i),  32'(resp_idx),  32'(vecs[i].e_idx));
      end
    end

    // Stall word 1 for five cycles.
    hs_data.delete(); hs_idx.delete(); rd_cnt = 0; last_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_0048; resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    wait_send(2'd1, ok);
    chk("stall_reach_word1", 32'(ok), 32'd1);
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_valid", i), 32'(resp_valid), 32'd1);
      chk($sformatf("stall%0d_data", i),  resp_data,       32'h121);
      chk($sformatf("stall%0d_idx", i),   32'(resp_idx),   32'd1);
      chk($sformatf("stall%0d_rd_en", i), 32'(mem_rd_en),  32'd0);
      @(negedge clk); #1;
    end
    resp_ready = 1'b1;
    wait_idle(ok);
    chk("stall_done", 32'(ok), 32'd1);
    chk("stall_words", 32'(hs_data.size()), 32'd4);
    chk("stall_rd_pulses", 32'(rd_cnt), 32'd4);
    chk("stall_last_count", 32'(last_cnt), 32'd1);
    if (hs_data.size() == 4) begin
      chk("stall_w0", hs_data[0], 32'h110);
      chk("stall_w1", hs_data[1], 32'h121);
      chk("stall_w2", hs_data[2], 32'h132);
      chk("stall_w3", hs_data[3], 32'h143);
      chk("stall_i3", 32'(hs_idx[3]), 32'd3);
    end

    // Request held high across a whole burst.
    hs_data.delete(); hs_idx.delete(); last_cnt = 0; acc_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_0048; resp_ready = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk); #1;
      if (last_cnt == 1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("held_first_burst_end", 32'(ok), 32'd1);
    chk("held_ready_after_last", 32'(req_ready), 32'd1);
    chk("held_accepts_first", 32'(acc_cnt), 32'd1);
    chk("held_words_first", 32'(hs_data.size()), 32'd4);
    @(negedge clk); #1;
    chk("held_accepts_second", 32'(acc_cnt), 32'd2);
    chk("held_busy_second", 32'(busy), 32'd1);
    req_valid = 1'b0;
    wait_idle(ok);
    chk("held_second_done", 32'(ok), 32'd1);
    chk("held_words_total", 32'(hs_data.size()), 32'd8);
    chk("held_last_total", 32'(last_cnt), 32'd2);

    // Reset while word 2 is waiting in SEND.
    base_hs = hs_data.size();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_0048; resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    wait_send(2'd2, ok);
    chk("rstmid_reach_word2", 32'(ok), 32'd1);
    base_last = last_cnt;
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rstmid_valid", 32'(resp_valid), 32'd0);
    chk("rstmid_busy",  32'(busy),       32'd0);
    chk("rstmid_ready", 32'(req_ready),  32'd1);
    chk("rstmid_last",  32'(resp_last),  32'd0);
    chk("rstmid_data",  resp_data,       32'd0);
    chk("rstmid_idx",   32'(resp_idx),   32'd0);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (resp_valid) seen_valid++;
    end
    chk("rstmid_no_more_valid", 32'(seen_valid), 32'd0);
    chk("rstmid_no_last", 32'(last_cnt), 32'(base_last));
    chk("rstmid_words", 32'(hs_data.size() - base_hs), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
